// File: rtl/miner_pkg.sv
// Shared definitions for the mining job dispatcher: FSM encoding, job field
// geometry and a saturating counter helper.
package miner_pkg;

    localparam int WORK_BITS   = 640;
    localparam int TARGET_BITS = 64;
    localparam int TS_LSB      = 320;
    localparam int TS_MSB      = 383;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_RUN   = 3'd3
`ifdef NONCE_ROLL_EN
        ,
        ST_ROLL  = 3'd4
`endif
    } state_e;

    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [4:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {4'b0000, b};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant among N requests when enabled; priority
// restarts just after the most recent grant.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N-1:0]     req,
    input  logic             en,
    output logic [N-1:0]     grant,
    output logic [PTR_W-1:0] ptr
);

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] idx;
    logic             hit;

    always_comb begin
        grant = '0;
        ptr_d = ptr_q;
        hit   = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = PTR_W'((int'(ptr_q) + k) % N);
            if (en && !hit && req[idx]) begin
                grant[idx] = 1'b1;
                hit        = 1'b1;
                ptr_d      = PTR_W'((int'(idx) + 1) % N);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/nonce_dispatcher.sv
// Job sequencer and result funnel between the UART parser and NUM_CORES hash
// cores. Define NONCE_ROLL_EN to bump the header timestamp and restart on exhaustion.
module nonce_dispatcher
    import miner_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int RES_GAP   = 32768,
    localparam int PTR_W    = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    valid,
    input  logic [WORK_BITS-1:0]    work,
    input  logic [TARGET_BITS-1:0]  target,
    output logic                    found,
    output logic [31:0]             nonce,
    output logic                    busy,
    output logic [WORK_BITS-1:0]    core_work,
    output logic [TARGET_BITS-1:0]  core_target,
    output logic [32*NUM_CORES-1:0] core_base,
    output logic [NUM_CORES-1:0]    core_start,
    output logic [NUM_CORES-1:0]    core_abort,
    input  logic [NUM_CORES-1:0]    core_done,
    input  logic [NUM_CORES-1:0]    core_found,
    input  logic [32*NUM_CORES-1:0] core_nonce,
    output logic [7:0]              drop_count,
    output logic [2:0]              dbg_state,
    output logic [PTR_W-1:0]        dbg_arb_ptr
);

    localparam int               GAP_W    = (RES_GAP > 1) ? $clog2(RES_GAP) : 1;
    // A grant at cycle g permits the next one at g + RES_GAP.
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(RES_GAP - 1);
    localparam logic [63:0]      SPAN     = 64'h1_0000_0000 / 64'(NUM_CORES);

    state_e                   state_q, state_d;
    logic [WORK_BITS-1:0]     work_q, work_d;
    logic [TARGET_BITS-1:0]   target_q, target_d;
    logic [NUM_CORES-1:0]     done_q, done_d;
    logic [NUM_CORES-1:0]     full_q, full_d;
    logic [32*NUM_CORES-1:0]  hold_q, hold_d;
    logic [GAP_W-1:0]         gap_q, gap_d;
    logic [31:0]              nonce_q, nonce_d;
    logic [7:0]               drop_q, drop_d;
    logic [NUM_CORES-1:0]     grant;
    logic [31:0]              grant_nonce;
    logic [4:0]               drop_n;
    logic                     all_done;
    logic                     arb_en;
    logic                     any_grant;

    always_comb begin
        state_d     = state_q;
        work_d      = work_q;
        target_d    = target_q;
        done_d      = '0;
        core_abort  = '0;
        core_start  = '0;
        core_base   = '0;
        busy        = (state_q != ST_IDLE);
        all_done    = &(done_q | core_done);
        unique case (state_q)
            ST_IDLE: ;
            ST_LOAD: begin
                core_abort = '1;
                state_d    = ST_START;
            end
            ST_START: begin
                core_start = '1;
                for (int i = 0; i < NUM_CORES; i++) begin
                    core_base[32*i +: 32] = 32'(64'(i) * SPAN);
                end
                state_d = ST_RUN;
            end
            ST_RUN: begin
                done_d = done_q | core_done;
                if (all_done) begin
`ifdef NONCE_ROLL_EN
                    state_d = ST_ROLL;
`else
                    state_d = ST_IDLE;
`endif
                end
            end
`ifdef NONCE_ROLL_EN
            ST_ROLL: begin
                work_d[TS_MSB:TS_LSB] = work_q[TS_MSB:TS_LSB] + 64'd1;
                state_d               = ST_START;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
        // A new job overrides anything in flight, including a pending restart.
        if (valid) begin
            state_d  = ST_LOAD;
            work_d   = work;
            target_d = target;
        end
    end

    assign arb_en = (gap_q == '0) && (state_q != ST_LOAD);

    rr_arbiter #(.N(NUM_CORES), .PTR_W(PTR_W)) u_arb (
        .clock (clock),
        .reset (reset),
        .req   (full_q),
        .en    (arb_en),
        .grant (grant),
        .ptr   (dbg_arb_ptr)
    );

    always_comb begin
        any_grant   = |grant;
        grant_nonce = '0;
        full_d      = full_q;
        hold_d      = hold_q;
        drop_n      = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (grant[i]) begin
                grant_nonce = grant_nonce | hold_q[32*i +: 32];
            end
            if (state_q == ST_LOAD) begin
                full_d[i] = 1'b0;
            end else if (core_found[i]) begin
                // A hold being granted this cycle frees its slot for the new result.
                if (full_q[i] && !grant[i]) begin
                    drop_n = drop_n + 5'd1;
                end else begin
                    full_d[i]            = 1'b1;
                    hold_d[32*i +: 32]   = core_nonce[32*i +: 32];
                end
            end else if (grant[i]) begin
                full_d[i] = 1'b0;
            end
        end
        drop_d  = sat_add8(drop_q, drop_n);
        nonce_d = any_grant ? grant_nonce : nonce_q;
        if (any_grant) begin
            gap_d = GAP_LOAD;
        end else if (gap_q != '0) begin
            gap_d = gap_q - GAP_W'(1);
        end else begin
            gap_d = gap_q;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            work_q   <= '0;
            target_q <= '0;
            done_q   <= '0;
            full_q   <= '0;
            hold_q   <= '0;
            gap_q    <= '0;
            nonce_q  <= '0;
            drop_q   <= '0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            target_q <= target_d;
            done_q   <= done_d;
            full_q   <= full_d;
            hold_q   <= hold_d;
            gap_q    <= gap_d;
            nonce_q  <= nonce_d;
            drop_q   <= drop_d;
        end
    end

    assign found       = any_grant;
    assign nonce       = nonce_d;
    assign core_work   = work_q;
    assign core_target = target_q;
    assign drop_count  = drop_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_nonce_dispatcher.sv
// Randomized bench for nonce_dispatcher (NUM_CORES=4, RES_GAP=8) with a
// cycle reference model and an expected-nonce scoreboard.
module tb_nonce_dispatcher;

    localparam int N   = 4;
    localparam int GAP = 8;
    localparam int P_IDLE = 0, P_LOAD = 1, P_START = 2, P_RUN = 3, P_ROLL = 4;

    logic         clock = 1'b0;
    logic         reset;
    logic         valid;
    logic [639:0] work;
    logic [63:0]  target;
    logic         found;
    logic [31:0]  nonce;
    logic         busy;
    logic [639:0] core_work;
    logic [63:0]  core_target;
    logic [127:0] core_base;
    logic [3:0]   core_start, core_abort, core_done, core_found;
    logic [127:0] core_nonce;
    logic [7:0]   drop_count;
    logic [2:0]   dbg_state;
    logic [1:0]   dbg_arb_ptr;

    nonce_dispatcher #(.NUM_CORES(N), .RES_GAP(GAP)) dut (
        .clock       (clock),
        .reset       (reset),
        .valid       (valid),
        .work        (work),
        .target      (target),
        .found       (found),
        .nonce       (nonce),
        .busy        (busy),
        .core_work   (core_work),
        .core_target (core_target),
        .core_base   (core_base),
        .core_start  (core_start),
        .core_abort  (core_abort),
        .core_done   (core_done),
        .core_found  (core_found),
        .core_nonce  (core_nonce),
        .drop_count  (drop_count),
        .dbg_state   (dbg_state),
        .dbg_arb_ptr (dbg_arb_ptr)
    );

    always #5 clock = ~clock;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    logic [31:0] exp_q[$];
    int          found_cyc[$];

    // Reference state: what the spec says the dispatcher holds after each edge.
    int           m_phase;
    bit           m_full[N];
    logic [31:0]  m_hold[N];
    bit           m_done[N];
    int           m_gap;
    int           m_ptr;
    int           m_drop;
    logic [31:0]  m_last;
    logic [639:0] m_work;
    logic [63:0]  m_target;

    task automatic check(input string tag, input logic [639:0] act, input logic [639:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = P_IDLE; m_gap = 0; m_ptr = 0; m_drop = 0;
        m_last = '0; m_work = '0; m_target = '0;
        for (int i = 0; i < N; i++) begin
            m_full[i] = 0; m_hold[i] = '0; m_done[i] = 0;
        end
    endtask

    function automatic int m_grant();
        if (m_gap != 0 || m_phase == P_LOAD) return -1;
        for (int k = 0; k < N; k++) begin
            if (m_full[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic check_outputs();
        int          g;
        logic [31:0] exp_nonce;
        g = m_grant();
        exp_nonce = m_last;
        if (g >= 0) begin
            exp_nonce = m_hold[g];
            exp_q.push_back(m_hold[g]);
        end
        if (found === 1'b1) begin
            found_cyc.push_back(cyc);
            if (exp_q.size() == 0) check("found_spurious", 1, 0);
            else check("found_nonce", nonce, exp_q.pop_front());
        end
        check("found", found, g >= 0);
        check("nonce", nonce, exp_nonce);
        check("busy", busy, m_phase != P_IDLE);
        check("abort", core_abort, m_phase == P_LOAD ? 4'hF : 4'h0);
        check("start", core_start, m_phase == P_START ? 4'hF : 4'h0);
        check("base", core_base, m_phase == P_START ?
              {32'hC000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000} : 128'h0);
        check("work", core_work, m_work);
        check("target", core_target, m_target);
        check("drops", drop_count, m_drop);
    endtask

    task automatic model_step(input logic v, input logic [3:0] cf, input logic [127:0] cn,
                              input logic [3:0] cd);
        int g;
        bit all;
        g = m_grant();
        all = 1;
        for (int i = 0; i < N; i++) if (!(m_done[i] || cd[i])) all = 0;
        if (g >= 0) m_last = m_hold[g];
        for (int i = 0; i < N; i++) begin
            if (m_phase == P_LOAD) m_full[i] = 0;
            else if (cf[i]) begin
                if (m_full[i] && g != i) m_drop = (m_drop < 255) ? m_drop + 1 : 255;
                else begin m_full[i] = 1; m_hold[i] = cn[32*i +: 32]; end
            end else if (g == i) m_full[i] = 0;
            m_done[i] = (m_phase == P_RUN) ? (m_done[i] || cd[i]) : 0;
        end
        if (g >= 0) begin m_ptr = (g + 1) % N; m_gap = GAP - 1; end
        else if (m_gap > 0) m_gap--;
        if (v) begin
            m_phase = P_LOAD; m_work = work; m_target = target;
        end else begin
            case (m_phase)
                P_LOAD:  m_phase = P_START;
                P_START: m_phase = P_RUN;
                P_RUN: if (all) begin
`ifdef NONCE_ROLL_EN
                    m_phase = P_ROLL;
`else
                    m_phase = P_IDLE;
`endif
                end
                P_ROLL: begin
                    m_work[383:320] = m_work[383:320] + 64'd1;
                    m_phase = P_START;
                end
                default: ;
            endcase
        end
    endtask

    task automatic tick(input logic v, input logic [3:0] cf, input logic [127:0] cn,
                        input logic [3:0] cd);
        @(negedge clock);
        cyc++;
        check_outputs();
        valid = v; core_found = cf; core_nonce = cn; core_done = cd;
        model_step(v, cf, cn, cd);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(0, 4'h0, 128'h0, 4'h0);
    endtask

    task automatic job(input bit fixed_ts);
        for (int k = 0; k < 20; k++) work[32*k +: 32] = $urandom();
        if (fixed_ts) work[383:320] = 64'h0000_0000_FFFF_FFFF;
        target = {$urandom(), $urandom()};
        tick(1, 4'h0, 128'h0, 4'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        logic [3:0]   cf, cd;
        logic [127:0] cn;
        logic         v;
        int           start_cyc;
        int           rate;
        reset = 1'b1; valid = 1'b0; work = '0; target = '0;
        core_done = '0; core_found = '0; core_nonce = '0;
        model_reset();
        #1;
        check_outputs();
        check("reset_state", dbg_state, 3'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;

        // Job start: abort, then start with evenly split bases.
        job(1);
        idle(3);

        // Cores 1 and 3 report together; second result waits out the gap.
        found_cyc.delete();
        tick(0, 4'b1010, {32'h33, 32'h0, 32'h11, 32'h0}, 4'h0);
        start_cyc = cyc;
        idle(20);
        check("pair_count", found_cyc.size(), 2);
        if (found_cyc.size() == 2) begin
            check("pair_latency", found_cyc[0] - start_cyc, 1);
            check("pair_spacing", found_cyc[1] - found_cyc[0], GAP);
        end

        // Core 2 reports twice while the gap blocks it.
        tick(0, 4'b0001, {96'h0, $urandom()}, 4'h0);
        tick(0, 4'b0100, {32'h0, $urandom(), 64'h0}, 4'h0);
        tick(0, 4'b0100, {32'h0, $urandom(), 64'h0}, 4'h0);
        idle(1);
        check("drop_one", drop_count, 8'd1);
        idle(20);

        // Exhaustion.
        tick(0, 4'h0, 128'h0, 4'b0011);
        tick(0, 4'h0, 128'h0, 4'b1100);
        idle(1);
`ifdef NONCE_ROLL_EN
        check("roll_busy", busy, 1'b1);
        idle(1);
        check("roll_ts", core_work[383:320], 64'h0000_0001_0000_0000);
        check("roll_start", core_start, 4'hF);
`else
        check("done_busy", busy, 1'b0);
`endif
        idle(20);

        // New job while core 0 still holds a result.
        job(0);
        idle(3);
        tick(0, 4'b0010, {64'h0, $urandom(), 32'h0}, 4'h0);
        tick(0, 4'b0001, {96'h0, $urandom()}, 4'h0);
        found_cyc.delete();
        job(0);
        idle(15);
        check("flushed_hold", found_cyc.size(), 0);

        // Random traffic, light then heavy enough to saturate the drop count.
        for (int n = 0; n < 3000; n++) begin
            rate = (n < 1500) ? 40 : 3;
            v = ($urandom_range(0, 199) == 0);
            for (int i = 0; i < N; i++) begin
                cf[i] = ($urandom_range(0, rate - 1) == 0);
                cd[i] = ($urandom_range(0, 39) == 0);
                cn[32*i +: 32] = $urandom();
            end
            if (v) begin
                for (int k = 0; k < 20; k++) work[32*k +: 32] = $urandom();
                target = {$urandom(), $urandom()};
            end
            tick(v, cf, cn, cd);
        end
        check("drop_saturated", drop_count, 8'd255);

        // Asynchronous reset in the middle of a job.
        job(0);
        idle(3);
        tick(0, 4'b0001, {96'h0, $urandom()}, 4'h0);
        @(negedge clock);
        valid = 1'b0; core_found = '0; core_done = '0; core_nonce = '0;
        #2 reset = 1'b1;
        #1;
        check("rst_found", found, 1'b0);
        check("rst_nonce", nonce, 32'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_work", core_work, 640'h0);
        check("rst_target", core_target, 64'h0);
        check("rst_drops", drop_count, 8'h0);
        check("rst_state", dbg_state, 3'd0);
        check("rst_ptr", dbg_arb_ptr, 2'd0);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        exp_q.delete();
        idle(5);

        check("sb_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
